addsub_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit ripple adder/subtractor (mode m: 0=add, 1=subtract via b^m, cin=m)

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_core.sv | 26 ++
 rtl/addsub_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_addsub_share_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the add/subtract arbiter slice: default width, operation mode and result record.
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_e;

    typedef struct packed {
        logic [ADDSUB_WIDTH-1:0] sum;
        logic                    cout;
        logic                    ovf;
    } addsub_res_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple adder/subtractor: subtract is a + ~b + 1, with carry and signed overflow flags.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             m_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    addsub_op_e       op;
    logic [WIDTH-1:0] bx;

    always_comb begin
        op = addsub_op_e'(m_i);
        bx = (op == OP_SUB) ? ~b_i : b_i;
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, bx} + (WIDTH+1)'(m_i);
        // Overflow: operands agree in sign but the result does not.
        ovf_o = (a_i[WIDTH-1] == bx[WIDTH-1]) & (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_share_arbiter.sv
// Round-robin sharing of one adder/subtractor among NREQ requesters with a single registered result slot.
// Optional ADDSUB_STATS_EN adds per-requester 8-bit saturating grant counters on stat_grants.
module addsub_share_arbiter
    import addsub_pkg::*;
#(
    parameter  int WIDTH = ADDSUB_WIDTH,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_m,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout,
    output logic                  res_ovf,
    output logic [IDW-1:0]        res_id
`ifdef ADDSUB_STATS_EN
    ,
    output logic [NREQ*8-1:0]     stat_grants
`endif
);

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_ovf_q, res_ovf_d;
    logic [IDW-1:0]   res_id_q, res_id_d;

    logic             slot_free;
    logic             found;
    logic             grant_any;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             m_sel;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout, core_ovf;

    assign slot_free = !res_valid_q || res_ready;

    always_comb begin : arb
        int       idx;
        logic [IDW-1:0] idx_w;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        idx_w   = '0;
        // Search starts just after the last winner and wraps, so the last winner ranks lowest.
        for (int off = 1; off <= NREQ; off++) begin
            idx   = (int'(rr_ptr_q) + off) % NREQ;
            idx_w = IDW'(idx);
            if (!found && req_valid[idx_w]) begin
                found   = 1'b1;
                win_idx = idx_w;
            end
        end
    end

    assign grant_any = rst_n && slot_free && found;
    assign req_ready = grant_any ? (NREQ'(1) << win_idx) : '0;

    assign a_sel = req_a[int'(win_idx)*WIDTH +: WIDTH];
    assign b_sel = req_b[int'(win_idx)*WIDTH +: WIDTH];
    assign m_sel = req_m[win_idx];

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a_i    (a_sel),
        .b_i    (b_sel),
        .m_i    (m_sel),
        .sum_o  (core_sum),
        .cout_o (core_cout),
        .ovf_o  (core_ovf)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        res_id_d    = res_id_q;
        if (grant_any) begin
            rr_ptr_d    = win_idx;
            res_valid_d = 1'b1;
            res_sum_d   = core_sum;
            res_cout_d  = core_cout;
            res_ovf_d   = core_ovf;
            res_id_d    = win_idx;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= IDW'(NREQ - 1);
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;
    assign res_id    = res_id_q;

`ifdef ADDSUB_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] stat_q [NREQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!rst_n) begin
                stat_q[i] <= '0;
            end else if (req_valid[i] && req_ready[i]) begin
                stat_q[i] <= sat_inc(stat_q[i]);
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[g*8 +: 8] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Directed bench for addsub_share_arbiter (WIDTH=4, NREQ=4); stats checks apply when ADDSUB_STATS_EN is defined.
module tb_addsub_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_m;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_sum;
    logic        res_cout;
    logic        res_ovf;
    logic [1:0]  res_id;
`ifdef ADDSUB_STATS_EN
    logic [31:0] stat_grants;
`endif

    int checks;
    int failures;

    addsub_share_arbiter #(.WIDTH(4), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_m     (req_m),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .res_id    (res_id)
`ifdef ADDSUB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  m;
        logic        rr;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [3:0]  e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic [1:0]  e_id;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic v, input logic [3:0] s,
                             input logic c, input logic o, input logic [1:0] id);
        check({tag, ".res_valid"}, 32'(res_valid), 32'(v));
        check({tag, ".res_sum"},   32'(res_sum),   32'(s));
        check({tag, ".res_cout"},  32'(res_cout),  32'(c));
        check({tag, ".res_ovf"},   32'(res_ovf),   32'(o));
        check({tag, ".res_id"},    32'(res_id),    32'(id));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = 16'hF941;
        req_b     = 16'h1842;
        req_m     = 4'b0000;
        res_ready = 1'b1;

        // vld, a, b, m, res_ready, exp ready, exp valid, sum, cout, ovf, id
        vecs[0]  = '{4'b0001, 16'h0005, 16'h0003, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'd8,  1'b0, 1'b1, 2'd0};
        vecs[1]  = '{4'b0010, 16'h0050, 16'h0030, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'd2,  1'b1, 1'b0, 2'd1};
        vecs[2]  = '{4'b0010, 16'h0030, 16'h0050, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'd14, 1'b0, 1'b0, 2'd1};
        vecs[3]  = '{4'b1111, 16'hF941, 16'h1842, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'd1,  1'b1, 1'b1, 2'd2};
        vecs[4]  = '{4'b1111, 16'hF941, 16'h1842, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'd0,  1'b1, 1'b0, 2'd3};
        vecs[5]  = '{4'b1111, 16'hF941, 16'h1842, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'd3,  1'b0, 1'b0, 2'd0};
        vecs[6]  = '{4'b1111, 16'hF941, 16'h1842, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'd8,  1'b0, 1'b1, 2'd1};
        vecs[7]  = '{4'b1111, 16'hF941, 16'h1842, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'd1,  1'b1, 1'b1, 2'd2};
        vecs[8]  = '{4'b0000, 16'hF941, 16'h1842, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd1,  1'b1, 1'b1, 2'd2};
        vecs[9]  = '{4'b0001, 16'h0008, 16'h0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'd7,  1'b1, 1'b1, 2'd0};
        vecs[10] = '{4'b1000, 16'h6000, 16'h6000, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'd0,  1'b1, 1'b0, 2'd3};

        // Reset state, with requests pending during reset.
        tick();
        check("rst.req_ready", 32'(req_ready), 32'h0);
        tick();
        check_res("rst", 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            req_valid = vecs[i].vld;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            req_m     = vecs[i].m;
            res_ready = vecs[i].rr;
            #1;
            check($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            tick();
            check_res($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_sum,
                      vecs[i].e_cout, vecs[i].e_ovf, vecs[i].e_id);
        end

        // Backpressure: slot full and not drained, so no grant and stable outputs.
        req_valid = 4'b1111;
        req_a     = 16'hF941;
        req_b     = 16'h1842;
        req_m     = 4'b0000;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d.req_ready", k), 32'(req_ready), 32'h0);
            tick();
            check_res($sformatf("bp%0d", k), 1'b1, 4'd0, 1'b1, 1'b0, 2'd3);
        end
        res_ready = 1'b1;
        #1;
        check("drain.req_ready", 32'(req_ready), 32'b0001);
        tick();
        check_res("drain", 1'b1, 4'd3, 1'b0, 1'b0, 2'd0);

        // Reset while a result is held: result discarded, pointer back to its start.
        rst_n     = 1'b0;
        res_ready = 1'b0;
        #1;
        check("rst2.req_ready", 32'(req_ready), 32'h0);
        tick();
        check_res("rst2", 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b0011;
        #1;
        check("rst2.grant", 32'(req_ready), 32'b0001);
        tick();
        check_res("rst2.res", 1'b1, 4'd3, 1'b0, 1'b0, 2'd0);

`ifdef ADDSUB_STATS_EN
        req_valid = 4'b0100;
        for (int k = 0; k < 300; k++) tick();
        req_valid = 4'b0000;
        tick();
        check("stat0", 32'(stat_grants[7:0]),   32'd1);
        check("stat1", 32'(stat_grants[15:8]),  32'd0);
        check("stat2", 32'(stat_grants[23:16]), 32'd255);
        check("stat3", 32'(stat_grants[31:24]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
